// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: one outstanding fetch, DEPTH-entry FIFO.
// Optional stall counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_prefetch_buffer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] stall_cnt,
`endif
   output logic [31:0] out_pcplus4
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   target_pc;

   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_pc    [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          gnt_fire;
   logic          push;
   logic          pop;

   // Request is only raised when a slot is guaranteed for the response.
   assign mem_req   = rst && (state == REQ) && (count != FULL);
   assign mem_addr  = fetch_pc;
   assign gnt_fire  = mem_req && mem_gnt;
   assign push      = (state == WAIT) && mem_rvalid && !redirect;
   assign pop       = out_valid && out_ready;
   assign target_pc = redirect_pc & 32'hFFFF_FFFC;

   assign out_valid   = (count != '0);
   assign out_instr   = fifo_instr[rd_ptr];
   assign out_pc      = fifo_pc[rd_ptr];
   assign out_pcplus4 = out_pc + 32'd4;

   // Fetch FSM: tracks the single outstanding request and stale responses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= REQ;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else begin
         if (redirect) begin
            fetch_pc <= target_pc;
         end else if (gnt_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (gnt_fire) begin
            req_pc <= fetch_pc;
         end
         unique case (state)
            REQ: begin
               if (gnt_fire) begin
                  state <= redirect ? DROP : WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state <= REQ;
               end else if (redirect) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (mem_rvalid) begin
                  state <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

   // FIFO pointers and occupancy; redirect flushes everything left.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   // FIFO storage written with the returned word and its fetch address.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= mem_rdata;
         fifo_pc[wr_ptr]    <= req_pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating count of cycles in which decode has nothing to take.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (!out_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: memory responder, scoreboard monitor,
// directed scenarios for streaming, backpressure, redirects, wrap, reset.
module tb_fetch_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   fetch_prefetch_buffer #(
      .RESET_PC(32'h0000_0000),
      .DEPTH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
`ifdef FETCH_PERF_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .out_pcplus4(out_pcplus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pcp4;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   errors  = 0;

   int          grant_cnt = 0;
   int          rsp_lat   = 1;
   bit          pend      = 0;
   int          wait_cnt  = 0;
   logic [31:0] paddr     = '0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic expect_pc(input logic [31:0] pc, input logic [31:0] p4);
      exp_t e;
      e.pc    = pc;
      e.instr = data_of(pc);
      e.pcp4  = p4;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_grants(input int n);
      int tgt;
      int t;
      tgt = grant_cnt + n;
      t = 0;
      mem_gnt = 1'b1;
      while (grant_cnt < tgt && t < 200) begin
         cyc(1);
         t++;
      end
      mem_gnt = 1'b0;
      check("grant_count", grant_cnt, tgt);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         cyc(1);
         t++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // Memory responder: latch grants, answer after rsp_lat cycles.
   always @(negedge clk) begin
      if (rst && mem_req && mem_gnt) begin
         pend      = 1;
         paddr     = mem_addr;
         wait_cnt  = rsp_lat - 1;
         grant_cnt = grant_cnt + 1;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (pend) begin
            if (wait_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = data_of(paddr);
               pend       = 0;
            end else begin
               wait_cnt = wait_cnt - 1;
            end
         end
      end
   end

   // Scoreboard monitor: every completed transfer must match the queue head.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_pop: got pc %h want none", out_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_instr", out_instr, e.instr);
            check("out_pcplus4", out_pcplus4, e.pcp4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      cyc(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_stall", stall_cnt, 0);
`endif
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("first_req", mem_req, 1);
      check("first_addr", mem_addr, 32'h0);
      repeat (10) @(posedge clk);
      #1;
`ifdef FETCH_PERF_CNT_EN
      check("stall_10", stall_cnt, 32'd10);
`endif

      // Streaming
      out_ready = 1'b1;
      expect_pc(32'h00, 32'h04);
      expect_pc(32'h04, 32'h08);
      expect_pc(32'h08, 32'h0C);
      expect_pc(32'h0C, 32'h10);
      expect_pc(32'h10, 32'h14);
      run_grants(5);
      wait_drain();

      // Backpressure: two entries, then no request, head stable
      out_ready = 1'b0;
      expect_pc(32'h14, 32'h18);
      expect_pc(32'h18, 32'h1C);
      run_grants(2);
      cyc(3);
      check("full_mem_req", mem_req, 0);
      check("full_valid", out_valid, 1);
      check("hold_pc_a", out_pc, 32'h14);
      mem_gnt = 1'b1;
      cyc(2);
      mem_gnt = 1'b0;
      check("full_no_grant", grant_cnt, 7);
      check("hold_pc_b", out_pc, 32'h14);
      check("hold_instr", out_instr, data_of(32'h14));
      out_ready = 1'b1;
      wait_drain();

      // Redirect while waiting on a slow response
      rsp_lat = 3;
      run_grants(1);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      cyc(1);
      redirect = 1'b0;
      check("drop_mem_req", mem_req, 0);
      check("drop_addr", mem_addr, 32'h100);
      cyc(3);
      rsp_lat = 1;
      check("after_drop_req", mem_req, 1);
      check("after_drop_valid", out_valid, 0);
      expect_pc(32'h100, 32'h104);
      expect_pc(32'h104, 32'h108);
      run_grants(2);
      wait_drain();

      // Redirect coincident with grant
      cyc(2);
      mem_gnt = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      cyc(1);
      mem_gnt = 1'b0;
      redirect = 1'b0;
      check("coin_mem_req", mem_req, 0);
      check("coin_addr", mem_addr, 32'h200);
      cyc(2);
      check("coin_back_req", mem_req, 1);
      expect_pc(32'h200, 32'h204);
      run_grants(1);
      wait_drain();

      // Address wrap
      cyc(2);
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      cyc(1);
      redirect = 1'b0;
      check("wrap_addr", mem_addr, 32'hFFFF_FFF8);
      expect_pc(32'hFFFF_FFF8, 32'hFFFF_FFFC);
      expect_pc(32'hFFFF_FFFC, 32'h0000_0000);
      expect_pc(32'h0000_0000, 32'h0000_0004);
      run_grants(3);
      wait_drain();

      // Pop coincident with redirect: head delivered, rest flushed
      out_ready = 1'b0;
      expect_pc(32'h04, 32'h08);
      run_grants(2);
      cyc(2);
      check("pr_valid", out_valid, 1);
      check("pr_head", out_pc, 32'h04);
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0300;
      cyc(1);
      redirect = 1'b0;
      check("pr_flushed", out_valid, 0);
      check("pr_addr", mem_addr, 32'h300);
      expect_pc(32'h300, 32'h304);
      run_grants(1);
      wait_drain();

      // Reset in the middle of a wait, late response ignored
      rsp_lat = 3;
      run_grants(1);
      rst = 1'b0;
      #1;
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_addr", mem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("mid_rst_stall", stall_cnt, 0);
`endif
      cyc(1);
      rst = 1'b1;
      cyc(4);
      check("late_rsp_valid", out_valid, 0);
      check("late_rsp_req", mem_req, 1);
      check("late_rsp_addr", mem_addr, 32'h0);
      rsp_lat = 1;
      expect_pc(32'h00, 32'h04);
      run_grants(1);
      wait_drain();

      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
